sync_fifo_param: RTL

- Parametrised synchronous FIFO, successor to the team's fixed 8-bit x 4 FIFO.
- Adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
- Selectable read mode: standard (registered) or first-word-fall-through (FWFT).
- Sits between producer/consumer stages in the same clock domain.

---
 rtl/sync_fifo_param_if.sv | 34 +++
 rtl/sync_fifo_param.sv | 118 +++++++++++
 2 files changed

// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle between a producer/consumer pair and sync_fifo_param.
// The producer/consumer side uses the master modport, the FIFO uses slave.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic              clr_err;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, data_in, rd_en, clr_err,
    input  data_out, valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, clr_err,
    output data_out, valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds, sticky overflow/underflow flags and a selectable standard or
// first-word-fall-through read port. All outputs are registered and reflect
// the post-edge state.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              wr_acc, rd_acc;

  // Next-state: accept decisions on pre-edge flags, then pointers, count,
  // flags derived from the new count, sticky errors and the read port.
  always_comb begin
    wr_acc   = bus.wr_en && !full_q;
    rd_acc   = bus.rd_en && !empty_q;
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_C);
    aempty_d = (count_d <= AE_C);
    // A new error in the same cycle wins over clr_err.
    ovf_d    = (bus.wr_en && full_q)  || (ovf_q && !bus.clr_err);
    unf_d    = (bus.rd_en && empty_q) || (unf_q && !bus.clr_err);
    valid_d  = 1'b0;
    dout_d   = dout_q;
    if (FWFT != 0) begin
      valid_d = !empty_d;
      if (!empty_d) begin
        // The new head may be the word being written this very edge (write
        // into an empty FIFO, or pop of the last word alongside a write).
        if (wr_acc && (rd_ptr_d == wr_ptr_q)) dout_d = bus.data_in;
        else                                 dout_d = mem_q[rd_ptr_d];
      end
    end else begin
      if (rd_acc) begin
        valid_d = 1'b1;
        dout_d  = mem_q[rd_ptr_q];
      end
    end
  end

  // Storage array: written on accepted writes only, never reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.data_in;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= (AF_LEVEL == 0);
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      valid_q  <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      valid_q  <= valid_d;
      dout_q   <= dout_d;
    end
  end

  assign bus.data_out     = dout_q;
  assign bus.valid        = valid_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule
